// File: rtl/alu.sv
// Execute-stage ALU: 16 operations on 32-bit operands with a single registered result.
// EXT/INS take their field bounds from msb/lsb; CLZ/CLO return 0..32.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  msb,
  input  logic [4:0]  lsb,
  input  logic [3:0]  OP,
  output logic [31:0] Out
);

  localparam int unsigned W  = 32;
  localparam int unsigned SW = 5;
  localparam int unsigned CW = 6;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_LUI  = 4'd11,
    OP_EXT  = 4'd12,
    OP_INS  = 4'd13,
    OP_CLZ  = 4'd14,
    OP_CLO  = 4'd15
  } op_e;

  logic [W-1:0]  out_d;
  logic [W-1:0]  out_q;
  logic [SW-1:0] shamt;
  logic [SW-1:0] span;
  logic          field_ok;
  logic [W-1:0]  low_mask;
  logic [W-1:0]  field_mask;

  // Priority encode from the MSB; the count saturates at W when no set bit exists.
  function automatic logic [CW-1:0] lead_zeros(input logic [W-1:0] v);
    logic [CW-1:0] cnt;
    logic          done;
    cnt  = '0;
    done = 1'b0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (!done) begin
        if (v[i]) begin
          done = 1'b1;
        end else begin
          cnt = cnt + CW'(1);
        end
      end
    end
    return cnt;
  endfunction

  // Field masks shared by EXT and INS; span is only meaningful when msb >= lsb.
  always_comb begin
    shamt      = A[SW-1:0];
    field_ok   = (msb >= lsb);
    span       = msb - lsb;
    low_mask   = {W{1'b1}} >> (SW'(W - 1) - span);
    field_mask = low_mask << lsb;
  end

  always_comb begin
    out_d = '0;
    case (op_e'(OP))
      OP_ADD:  out_d = A + B;
      OP_SUB:  out_d = A - B;
      OP_AND:  out_d = A & B;
      OP_OR:   out_d = A | B;
      OP_XOR:  out_d = A ^ B;
      OP_NOR:  out_d = ~(A | B);
      OP_SLT:  out_d = W'($signed(A) < $signed(B));
      OP_SLTU: out_d = W'(A < B);
      OP_SLL:  out_d = B << shamt;
      OP_SRL:  out_d = B >> shamt;
      OP_SRA:  out_d = W'($signed(B) >>> shamt);
      OP_LUI:  out_d = {B[15:0], 16'h0000};
      OP_EXT:  out_d = field_ok ? ((A >> lsb) & low_mask) : '0;
      OP_INS:  out_d = field_ok ? ((B & ~field_mask) | ((A << lsb) & field_mask)) : B;
      OP_CLZ:  out_d = W'(lead_zeros(A));
      OP_CLO:  out_d = W'(lead_zeros(~A));
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign Out = out_q;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vectors, randomized ops against a bit-level reference model,
// pipelined back-to-back updates and asynchronous reset behaviour.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  msb;
  logic [4:0]  lsb;
  logic [3:0]  OP;
  logic [31:0] Out;

  int n_cmp = 0;
  int n_bad = 0;

  alu dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .msb   (msb),
    .lsb   (lsb),
    .OP    (OP),
    .Out   (Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  m;
    logic [4:0]  l;
    logic [31:0] exp;
  } vec_t;

  // Reference model built bit by bit from the operation definitions.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] m,
                                        input logic [4:0] l);
    logic [31:0] r;
    int sh;
    int n;
    r  = '0;
    sh = int'(a[4:0]);
    n  = 0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
      4'd6:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd7:  r = (a < b) ? 32'd1 : 32'd0;
      4'd8:  for (int i = 0; i < 32; i++) r[i] = (i - sh >= 0) ? b[i - sh] : 1'b0;
      4'd9:  for (int i = 0; i < 32; i++) r[i] = (i + sh < 32) ? b[i + sh] : 1'b0;
      4'd10: for (int i = 0; i < 32; i++) r[i] = (i + sh < 32) ? b[i + sh] : b[31];
      4'd11: r = 32'(b[15:0]) * 32'd65536;
      4'd12: if (m >= l) for (int i = int'(l); i <= int'(m); i++) r[i - int'(l)] = a[i];
      4'd13: begin
        r = b;
        if (m >= l) for (int i = int'(l); i <= int'(m); i++) r[i] = a[i - int'(l)];
      end
      4'd14: begin
        while (n < 32 && a[31 - n] == 1'b0) n++;
        r = 32'(n);
      end
      default: begin
        while (n < 32 && a[31 - n] == 1'b1) n++;
        r = 32'(n);
      end
    endcase
    return r;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] m, input logic [4:0] l);
    OP = op; A = a; B = b; msb = m; lsb = l;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(4'd3, 32'hDEADBEEF, 32'h1, 5'd0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (Out !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_hold: got %h want %h", Out, 32'h0);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[$];
    v.push_back('{4'd13, 32'h12345678, 32'hFFFFFFFF, 5'd3,  5'd0,  32'hFFFFFFF8});
    v.push_back('{4'd13, 32'h12345678, 32'hFFFFFFFF, 5'd11, 5'd12, 32'hFFFFFFFF});
    v.push_back('{4'd13, 32'h12345678, 32'hFFFFFFFF, 5'd15, 5'd8,  32'hFFFF78FF});
    v.push_back('{4'd13, 32'h12345678, 32'hFFFFFFFF, 5'd31, 5'd0,  32'h12345678});
    v.push_back('{4'd12, 32'h12345678, 32'h0,        5'd11, 5'd4,  32'h00000067});
    v.push_back('{4'd12, 32'h12345678, 32'h0,        5'd3,  5'd5,  32'h00000000});
    v.push_back('{4'd12, 32'h92345678, 32'h0,        5'd31, 5'd0,  32'h92345678});
    v.push_back('{4'd0,  32'hFFFFFFFF, 32'h1,        5'd0,  5'd0,  32'h00000000});
    v.push_back('{4'd1,  32'h0,        32'h1,        5'd0,  5'd0,  32'hFFFFFFFF});
    v.push_back('{4'd6,  32'hFFFFFFFF, 32'h1,        5'd0,  5'd0,  32'h00000001});
    v.push_back('{4'd7,  32'hFFFFFFFF, 32'h1,        5'd0,  5'd0,  32'h00000000});
    v.push_back('{4'd10, 32'h4,        32'h80000000, 5'd0,  5'd0,  32'hF8000000});
    v.push_back('{4'd11, 32'h0,        32'h1234,     5'd0,  5'd0,  32'h12340000});
    v.push_back('{4'd14, 32'h00010000, 32'h0,        5'd0,  5'd0,  32'd15});
    v.push_back('{4'd14, 32'h0,        32'h0,        5'd0,  5'd0,  32'd32});
    v.push_back('{4'd15, 32'hF0000000, 32'h0,        5'd0,  5'd0,  32'd4});
    v.push_back('{4'd15, 32'hFFFFFFFF, 32'h0,        5'd0,  5'd0,  32'd32});
    v.push_back('{4'd8,  32'h24,       32'h1,        5'd0,  5'd0,  32'h00000010});
    v.push_back('{4'd9,  32'h1F,       32'h80000000, 5'd0,  5'd0,  32'h00000001});
    v.push_back('{4'd5,  32'h0,        32'h0,        5'd7,  5'd2,  32'hFFFFFFFF});
    foreach (v[k]) begin
      drive(v[k].op, v[k].a, v[k].b, v[k].m, v[k].l);
      @(posedge clk);
      #1;
      n_cmp++;
      if (Out !== v[k].exp) begin
        n_bad++;
        $display("FAIL directed[%0d] op=%0d: got %h want %h", k, v[k].op, Out, v[k].exp);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, exp;
    logic [3:0]  op;
    logic [4:0]  m, l;
    for (int k = 0; k < 400; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      m  = 5'($urandom);
      l  = 5'($urandom);
      case ($urandom_range(0, 7))
        0: a = 32'h0;
        1: a = 32'hFFFFFFFF;
        2: a = a >> $urandom_range(0, 31);
        3: a = ~(a >> $urandom_range(0, 31));
        default: ;
      endcase
      exp = model(op, a, b, m, l);
      drive(op, a, b, m, l);
      @(posedge clk);
      #1;
      n_cmp++;
      if (Out !== exp) begin
        n_bad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h msb=%0d lsb=%0d: got %h want %h",
                 k, op, a, b, m, l, Out, exp);
      end
    end
  endtask

  // Inputs change mid-cycle; Out must hold until the next edge, then show only the latest inputs.
  task automatic test_back_to_back();
    logic [31:0] held, exp;
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int k = 0; k < 40; k++) begin
      held = Out;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      drive(4'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom));
      #2;
      n_cmp++;
      if (Out !== held) begin
        n_bad++;
        $display("FAIL b2b_hold[%0d]: got %h want %h", k, Out, held);
      end
      drive(op, a, b, 5'd20, 5'd4);
      exp = model(op, a, b, 5'd20, 5'd4);
      @(posedge clk);
      #1;
      n_cmp++;
      if (Out !== exp) begin
        n_bad++;
        $display("FAIL b2b_load[%0d] op=%0d: got %h want %h", k, op, Out, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp;
    drive(4'd3, 32'hA5A50000, 32'h00005A5A, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    n_cmp++;
    if (Out !== 32'hA5A55A5A) begin
      n_bad++;
      $display("FAIL pre_reset_load: got %h want %h", Out, 32'hA5A55A5A);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (Out !== 32'h0) begin
      n_bad++;
      $display("FAIL async_clear: got %h want %h", Out, 32'h0);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (Out !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_over_edge: got %h want %h", Out, 32'h0);
    end
    drive(4'd13, 32'h000000AB, 32'h11111111, 5'd23, 5'd16);
    exp = 32'h11AB1111;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (Out !== 32'h0) begin
      n_bad++;
      $display("FAIL release_no_edge: got %h want %h", Out, 32'h0);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (Out !== exp) begin
      n_bad++;
      $display("FAIL first_post_reset: got %h want %h", Out, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(4'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    #1;
    n_cmp++;
    if (Out !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_immediate: got %h want %h", Out, 32'h0);
    end
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running want finished");
    $fatal(1);
  end

endmodule
